// File: rtl/sram_write_sequencer.sv
// -----------------------------------------------------------------------------
// sram_write_sequencer
//
// Purpose:
//   Downstream stage of the ADC capture writer. Buffers 64-bit capture words
//   in an internal FIFO and, on each burst request, writes BURST_LEN words to
//   an external asynchronous SRAM as four 16-bit halfwords each (low halfword
//   first, at consecutive halfword addresses). Keeps a linear SRAM address
//   that wraps to zero, and reports dropped pushes and address wrap.
//
// Ports:
//   clk            in   1        system clock
//   rst            in   1        asynchronous reset, active-low
//   wr_data        in   64       capture word
//   fifo_wr        in   1        push wr_data this cycle
//   burst_start    in   1        request one burst of BURST_LEN words
//   clear          in   1        synchronous flush of FIFO, queue, address, flags
//   sram_addr      out  ADDR_W   SRAM halfword address
//   sram_dq        out  16       SRAM write data
//   sram_dq_oe     out  1        drive enable for the SRAM data pins
//   sram_ce_n      out  1        chip enable, active-low
//   sram_we_n      out  1        write enable, active-low
//   sram_oe_n      out  1        output enable, held high (write-only)
//   busy           out  1        burst in progress or queued
//   fifo_count     out  CNT_W    current FIFO occupancy
//   words_written  out  32       64-bit words committed to SRAM since clear
//   overflow       out  1        sticky: a push was dropped
//   wrapped        out  1        sticky: sram_addr wrapped past its maximum
// -----------------------------------------------------------------------------
module sram_write_sequencer #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [63:0]                   wr_data,
   input  logic                          fifo_wr,
   input  logic                          burst_start,
   input  logic                          clear,
   output logic [ADDR_W-1:0]             sram_addr,
   output logic [15:0]                   sram_dq,
   output logic                          sram_dq_oe,
   output logic                          sram_ce_n,
   output logic                          sram_we_n,
   output logic                          sram_oe_n,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [31:0]                   words_written,
   output logic                          overflow,
   output logic                          wrapped
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned QMAX   = FIFO_DEPTH / BURST_LEN;
   localparam int unsigned Q_W    = $clog2(QMAX) + 1;
   localparam int unsigned WIDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 2);

   localparam logic [CNT_W-1:0]  L_DEPTH = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  L_BURST = CNT_W'(BURST_LEN);
   localparam logic [Q_W-1:0]    L_QMAX  = Q_W'(QMAX);
   localparam logic [WIDX_W-1:0] L_WLAST = WIDX_W'(BURST_LEN - 1);
   localparam logic [WAIT_W-1:0] L_WAIT  = WAIT_W'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD
   } state_t;

   // FIFO storage and bookkeeping
   logic [63:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;

   // burst request queue
   logic [Q_W-1:0]     r_queued;

   // write sequencer
   state_t             r_state;
   logic [63:0]        r_word;
   logic [1:0]         r_half;
   logic [WIDX_W-1:0]  r_widx;
   logic [WAIT_W-1:0]  r_wait;
   logic [ADDR_W-1:0]  r_addr;
   logic [15:0]        r_dq;
   logic               r_dq_oe;
   logic               r_ce_n;
   logic               r_we_n;
   logic [31:0]        r_words;
   logic               r_wrapped;

   logic               w_full;
   logic               w_ready;
   logic               w_last_half;
   logic               w_last_word;
   logic               w_burst_go;
   logic               w_pop;
   logic               w_push;
   logic               w_q_inc;
   logic [63:0]        w_head;

   assign w_full      = (r_count == L_DEPTH);
   assign w_ready     = (r_queued != '0) && (r_count >= L_BURST);
   assign w_last_half = (r_state == S_HOLD) && (r_half == 2'd3);
   assign w_last_word = (r_widx == L_WLAST);
   assign w_head      = r_mem[r_rd_ptr];

   // A new burst starts either from IDLE or directly after the final HOLD of
   // the previous burst, so back-to-back bursts leave no idle gap.
   assign w_burst_go = !clear &&
                       (((r_state == S_IDLE) && w_ready) ||
                        (w_last_half && w_last_word && w_ready));

   // The next word is popped on entry to the SETUP of its first halfword.
   assign w_pop   = w_burst_go || (!clear && w_last_half && !w_last_word);

   // A push into a full FIFO is accepted when a pop frees a slot that cycle.
   assign w_push  = !clear && fifo_wr && (!w_full || w_pop);
   assign w_q_inc = !clear && burst_start && (r_queued != L_QMAX);

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (fifo_wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Burst queue: saturating request counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_queued <= '0;
      end else if (clear) begin
         r_queued <= '0;
      end else begin
         case ({w_q_inc, w_burst_go})
            2'b10:   r_queued <= r_queued + Q_W'(1);
            2'b01:   r_queued <= r_queued - Q_W'(1);
            default: r_queued <= r_queued;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Halfword write sequencer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_word    <= '0;
         r_half    <= '0;
         r_widx    <= '0;
         r_wait    <= '0;
         r_addr    <= '0;
         r_dq      <= '0;
         r_dq_oe   <= 1'b0;
         r_ce_n    <= 1'b1;
         r_we_n    <= 1'b1;
         r_words   <= '0;
         r_wrapped <= 1'b0;
      end else if (clear) begin
         r_state   <= S_IDLE;
         r_word    <= '0;
         r_half    <= '0;
         r_widx    <= '0;
         r_wait    <= '0;
         r_addr    <= '0;
         r_dq      <= '0;
         r_dq_oe   <= 1'b0;
         r_ce_n    <= 1'b1;
         r_we_n    <= 1'b1;
         r_words   <= '0;
         r_wrapped <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_burst_go) begin
                  r_state <= S_SETUP;
                  r_word  <= w_head;
                  r_dq    <= w_head[15:0];
                  r_half  <= '0;
                  r_widx  <= '0;
                  r_ce_n  <= 1'b0;
                  r_dq_oe <= 1'b1;
                  r_we_n  <= 1'b1;
               end
            end

            S_SETUP: begin
               r_state <= S_PULSE;
               r_we_n  <= 1'b0;
               r_wait  <= '0;
            end

            S_PULSE: begin
               if (r_wait == L_WAIT) begin
                  r_state <= S_HOLD;
                  r_we_n  <= 1'b1;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end

            S_HOLD: begin
               r_addr <= r_addr + ADDR_W'(1);
               if (r_addr == '1) begin
                  r_wrapped <= 1'b1;
               end
               if (r_half != 2'd3) begin
                  r_half  <= r_half + 2'd1;
                  r_state <= S_SETUP;
                  case (r_half)
                     2'd0:    r_dq <= r_word[31:16];
                     2'd1:    r_dq <= r_word[47:32];
                     default: r_dq <= r_word[63:48];
                  endcase
               end else begin
                  r_words <= r_words + 32'd1;
                  if (!w_last_word) begin
                     r_widx  <= r_widx + WIDX_W'(1);
                     r_half  <= '0;
                     r_word  <= w_head;
                     r_dq    <= w_head[15:0];
                     r_state <= S_SETUP;
                  end else if (w_burst_go) begin
                     r_widx  <= '0;
                     r_half  <= '0;
                     r_word  <= w_head;
                     r_dq    <= w_head[15:0];
                     r_state <= S_SETUP;
                  end else begin
                     r_state <= S_IDLE;
                     r_ce_n  <= 1'b1;
                     r_dq_oe <= 1'b0;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_ce_n  <= 1'b1;
               r_dq_oe <= 1'b0;
               r_we_n  <= 1'b1;
            end
         endcase
      end
   end

   assign sram_addr     = r_addr;
   assign sram_dq       = r_dq;
   assign sram_dq_oe    = r_dq_oe;
   assign sram_ce_n     = r_ce_n;
   assign sram_we_n     = r_we_n;
   assign sram_oe_n     = 1'b1;
   assign busy          = (r_state != S_IDLE) || (r_queued != '0);
   assign fifo_count    = r_count;
   assign words_written = r_words;
   assign overflow      = r_overflow;
   assign wrapped       = r_wrapped;

endmodule

// File: tb/tb_sram_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_write_sequencer
//
// Directed bench for sram_write_sequencer. A default-parameter instance covers
// bursts, queuing, overflow, clear and reset; a second instance with a 4-bit
// address covers address wrap. Each write pulse is logged (address, data, bus
// enables, cycle) when sram_we_n falls, and the scenario tasks compare the log
// against words generated by mkword().
// -----------------------------------------------------------------------------
module tb_sram_write_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] wr_data;
   logic        fifo_wr, burst_start, clear;

   logic [17:0] sram_addr;
   logic [15:0] sram_dq;
   logic        sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, busy;
   logic [3:0]  fifo_count;
   logic [31:0] words_written;
   logic        overflow, wrapped;

   logic [63:0] t4_data;
   logic        t4_wr, t4_burst, t4_clear;
   logic [3:0]  a4_addr;
   logic [15:0] a4_dq;
   logic        a4_dq_oe, a4_ce_n, a4_we_n, a4_oe_n, a4_busy;
   logic [3:0]  a4_count;
   logic [31:0] a4_words;
   logic        a4_overflow, a4_wrapped;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   sram_write_sequencer u_dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .fifo_wr(fifo_wr),
      .burst_start(burst_start), .clear(clear),
      .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .busy(busy), .fifo_count(fifo_count), .words_written(words_written),
      .overflow(overflow), .wrapped(wrapped)
   );

   sram_write_sequencer #(.ADDR_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .wr_data(t4_data), .fifo_wr(t4_wr),
      .burst_start(t4_burst), .clear(t4_clear),
      .sram_addr(a4_addr), .sram_dq(a4_dq), .sram_dq_oe(a4_dq_oe),
      .sram_ce_n(a4_ce_n), .sram_we_n(a4_we_n), .sram_oe_n(a4_oe_n),
      .busy(a4_busy), .fifo_count(a4_count), .words_written(a4_words),
      .overflow(a4_overflow), .wrapped(a4_wrapped)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // write-pulse logs
   logic [17:0] log_addr [256];
   logic [15:0] log_dq   [256];
   logic        log_bus  [256];
   int          log_cyc  [256];
   int          m_n    = 0;
   int          m_low  = 0;
   logic        m_prev = 1'b1;

   always @(negedge clk) begin
      if (!sram_we_n) m_low = m_low + 1;
      if (m_prev && !sram_we_n && m_n < 256) begin
         log_addr[m_n] = sram_addr;
         log_dq[m_n]   = sram_dq;
         log_bus[m_n]  = !sram_ce_n && sram_dq_oe;
         log_cyc[m_n]  = cyc;
         m_n = m_n + 1;
      end
      m_prev = sram_we_n;
   end

   logic [3:0]  log4_addr [64];
   logic        log4_wrap [64];
   int          n4 = 0;
   logic        p4_prev = 1'b1;

   always @(negedge clk) begin
      if (p4_prev && !a4_we_n && n4 < 64) begin
         log4_addr[n4] = a4_addr;
         log4_wrap[n4] = a4_wrapped;
         n4 = n4 + 1;
      end
      p4_prev = a4_we_n;
   end

   function automatic logic [63:0] mkword(input int i);
      logic [15:0] n;
      n = 16'(i);
      return {16'h7000 + n, 16'h5000 + n, 20'h0, 12'h0A0 + n[11:0]};
   endfunction

   function automatic logic [15:0] half_of(input logic [63:0] w, input int h);
      return w[16*h +: 16];
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d, input logic bs);
      wr_data = d; fifo_wr = 1'b1; burst_start = bs;
      step();
      fifo_wr = 1'b0; burst_start = 1'b0;
   endtask

   task automatic strobe_burst();
      burst_start = 1'b1;
      step();
      burst_start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int done_cyc);
      int i = 0;
      while (busy && i < budget) begin step(); i++; end
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL idle_timeout busy=%0b required=0 within %0d cycles", busy, budget);
      end
      done_cyc = cyc;
   endtask

   task automatic wait_pulses(input int base, input int n, input int budget);
      int i = 0;
      while ((m_n - base) < n && i < budget) begin step(); i++; end
      checks++;
      if ((m_n - base) < n) begin
         failures++;
         $display("FAIL pulse_timeout pulses=%0d required=%0d", m_n - base, n);
      end
   endtask

   // compare logged pulses [base, base+n) against consecutive halfwords of
   // words first_word.., at addresses first_addr..
   task automatic check_pulses(input string tag, input int base, input int n,
                               input int first_word, input int first_addr);
      for (int k = 0; k < n && (base + k) < m_n; k++) begin
         logic [17:0] ea;
         logic [15:0] ed;
         ea = 18'(first_addr + k);
         ed = half_of(mkword(first_word + k / 4), k % 4);
         checks++;
         if (log_addr[base+k] !== ea || log_dq[base+k] !== ed || log_bus[base+k] !== 1'b1) begin
            failures++;
            $display("FAIL %s_pulse%0d addr=%0h dq=%0h bus=%0b required addr=%0h dq=%0h bus=1",
                     tag, k, log_addr[base+k], log_dq[base+k], log_bus[base+k], ea, ed);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; wr_data = '0; fifo_wr = 0; burst_start = 0; clear = 0;
      t4_data = '0; t4_wr = 0; t4_burst = 0; t4_clear = 0;
      step(); step();
      checks++;
      if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, busy, overflow, wrapped} !== 7'b1110000) begin
         failures++;
         $display("FAIL reset_ctrl we,ce,oe,dq_oe,busy,ovf,wrap=%b required=1110000",
                  {sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, busy, overflow, wrapped});
      end
      checks++;
      if (sram_addr !== 18'd0 || sram_dq !== 16'd0 || fifo_count !== 4'd0 || words_written !== 32'd0) begin
         failures++;
         $display("FAIL reset_data addr=%0h dq=%0h count=%0d words=%0d required all 0",
                  sram_addr, sram_dq, fifo_count, words_written);
      end
      checks++;
      if (a4_we_n !== 1'b1 || a4_addr !== 4'd0 || a4_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_dut4 we=%b addr=%0h busy=%b required 1,0,0", a4_we_n, a4_addr, a4_busy);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single_burst();
      int base = m_n, low0 = m_low, dc;
      for (int i = 0; i < 4; i++) push(mkword(i), i == 3);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL single_busy busy=%b required=1", busy); end
      wait_idle(300, dc);
      checks++;
      if (m_n - base !== 16) begin failures++; $display("FAIL single_count pulses=%0d required=16", m_n - base); end
      check_pulses("single", base, 16, 0, 0);
      checks++;
      if (dc - log_cyc[base] !== 63) begin
         failures++; $display("FAIL single_duration cycles=%0d required=63", dc - log_cyc[base]);
      end
      checks++;
      if (m_low - low0 !== 32) begin failures++; $display("FAIL single_we_low cycles=%0d required=32", m_low - low0); end
      checks++;
      if (words_written !== 32'd4 || fifo_count !== 4'd0 || sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
         failures++;
         $display("FAIL single_end words=%0d count=%0d ce_n=%b dq_oe=%b required 4,0,1,0",
                  words_written, fifo_count, sram_ce_n, sram_dq_oe);
      end
   endtask

   task automatic test_back_to_back();
      int base, dc;
      do_clear();
      base = m_n;
      for (int i = 0; i < 8; i++) push(mkword(10 + i), i == 3 || i == 7);
      wait_idle(400, dc);
      checks++;
      if (m_n - base !== 32) begin failures++; $display("FAIL b2b_count pulses=%0d required=32", m_n - base); end
      check_pulses("b2b", base, 32, 10, 0);
      checks++;
      if (log_cyc[base+16] - log_cyc[base+15] !== 4) begin
         failures++; $display("FAIL b2b_gap cycles=%0d required=4", log_cyc[base+16] - log_cyc[base+15]);
      end
      checks++;
      if (words_written !== 32'd8) begin failures++; $display("FAIL b2b_words words=%0d required=8", words_written); end
   endtask

   task automatic test_overflow();
      int base, dc;
      do_clear();
      base = m_n;
      for (int i = 0; i < 9; i++) push(mkword(20 + i), 1'b0);
      checks++;
      if (fifo_count !== 4'd8 || overflow !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ovf_state count=%0d ovf=%b busy=%b required 8,1,0", fifo_count, overflow, busy);
      end
      strobe_burst();
      strobe_burst();
      wait_idle(400, dc);
      checks++;
      if (m_n - base !== 32) begin failures++; $display("FAIL ovf_count pulses=%0d required=32", m_n - base); end
      check_pulses("ovf", base, 32, 20, 0);
      checks++;
      if (fifo_count !== 4'd0 || overflow !== 1'b1) begin
         failures++; $display("FAIL ovf_end count=%0d ovf=%b required 0,1", fifo_count, overflow);
      end
   endtask

   task automatic test_queue_saturation();
      int base, dc;
      do_clear();
      base = m_n;
      for (int i = 0; i < 3; i++) strobe_burst();
      checks++;
      if (busy !== 1'b1 || overflow !== 1'b0 || m_n != base) begin
         failures++; $display("FAIL sat_wait busy=%b ovf=%b pulses=%0d required 1,0,0", busy, overflow, m_n - base);
      end
      for (int i = 0; i < 8; i++) push(mkword(30 + i), 1'b0);
      wait_idle(400, dc);
      checks++;
      if (m_n - base !== 32 || words_written !== 32'd8) begin
         failures++; $display("FAIL sat_end pulses=%0d words=%0d required 32,8", m_n - base, words_written);
      end
      check_pulses("sat", base, 32, 30, 0);
   endtask

   task automatic test_wrap();
      int base = n4, i = 0;
      for (int k = 0; k < 8; k++) begin
         t4_data = mkword(k); t4_wr = 1'b1; t4_burst = (k == 3 || k == 7);
         step();
         t4_wr = 1'b0; t4_burst = 1'b0;
      end
      while (a4_busy && i < 400) begin step(); i++; end
      checks++;
      if (a4_busy) begin failures++; $display("FAIL wrap_timeout busy=%b required=0", a4_busy); end
      checks++;
      if (n4 - base !== 32) begin failures++; $display("FAIL wrap_count pulses=%0d required=32", n4 - base); end
      for (int k = 0; k < 32 && (base + k) < n4; k++) begin
         checks++;
         if (log4_addr[base+k] !== 4'(k % 16)) begin
            failures++; $display("FAIL wrap_addr%0d addr=%0h required=%0h", k, log4_addr[base+k], k % 16);
         end
      end
      checks++;
      if (log4_wrap[base+15] !== 1'b0 || log4_wrap[base+16] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_flag before=%b after=%b required 0,1", log4_wrap[base+15], log4_wrap[base+16]);
      end
      checks++;
      if (a4_wrapped !== 1'b1 || a4_words !== 32'd8) begin
         failures++; $display("FAIL wrap_end wrapped=%b words=%0d required 1,8", a4_wrapped, a4_words);
      end
   endtask

   task automatic test_clear_mid_pulse();
      int base;
      do_clear();
      base = m_n;
      for (int i = 0; i < 5; i++) push(mkword(40 + i), i == 3);
      wait_pulses(base, 2, 100);
      checks++;
      if (sram_we_n !== 1'b0 || sram_addr !== 18'd1) begin
         failures++; $display("FAIL clr_pre we_n=%b addr=%0h required 0,1", sram_we_n, sram_addr);
      end
      clear = 1'b1; fifo_wr = 1'b1; wr_data = mkword(99);
      step();
      clear = 1'b0; fifo_wr = 1'b0;
      checks++;
      if ({sram_we_n, sram_ce_n, sram_dq_oe, busy} !== 4'b1100) begin
         failures++; $display("FAIL clr_ctrl we,ce,dq_oe,busy=%b required=1100", {sram_we_n, sram_ce_n, sram_dq_oe, busy});
      end
      checks++;
      if (sram_addr !== 18'd0 || fifo_count !== 4'd0 || words_written !== 32'd0) begin
         failures++;
         $display("FAIL clr_data addr=%0h count=%0d words=%0d required 0,0,0", sram_addr, fifo_count, words_written);
      end
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (m_n - base !== 2 || busy !== 1'b0) begin
         failures++; $display("FAIL clr_quiet pulses=%0d busy=%b required 2,0", m_n - base, busy);
      end
   endtask

   task automatic test_async_reset();
      int base, dc;
      do_clear();
      base = m_n;
      for (int i = 0; i < 9; i++) push(mkword(50 + i), 1'b0);
      strobe_burst();
      wait_pulses(base, 2, 100);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({sram_we_n, sram_ce_n, sram_dq_oe, busy, overflow} !== 5'b11000) begin
         failures++;
         $display("FAIL arst_ctrl we,ce,dq_oe,busy,ovf=%b required=11000",
                  {sram_we_n, sram_ce_n, sram_dq_oe, busy, overflow});
      end
      checks++;
      if (sram_addr !== 18'd0 || sram_dq !== 16'd0 || fifo_count !== 4'd0 || words_written !== 32'd0 ||
          a4_wrapped !== 1'b0) begin
         failures++;
         $display("FAIL arst_data addr=%0h dq=%0h count=%0d words=%0d wrap4=%b required all 0",
                  sram_addr, sram_dq, fifo_count, words_written, a4_wrapped);
      end
      step();
      rst = 1'b1;
      step();
      base = m_n;
      for (int i = 0; i < 4; i++) push(mkword(60 + i), i == 3);
      wait_idle(300, dc);
      checks++;
      if (m_n - base !== 16 || words_written !== 32'd4) begin
         failures++; $display("FAIL arst_after pulses=%0d words=%0d required 16,4", m_n - base, words_written);
      end
      check_pulses("arst", base, 16, 60, 0);
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_overflow();
      test_queue_saturation();
      test_wrap();
      test_clear_mid_pulse();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
